prci_rstseq: RTL and testbench

PRCI_RSTSEQ -- requirements
Module: prci_rstseq

---
 rtl/prci_rstseq.sv | 226 ++++++++++++++++++++++
 tb/tb_prci_rstseq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prci_rstseq.sv
// prci_rstseq -- PLL-lock filtered, ordered reset-release sequencer.
// Domains leave reset one at a time in ascending order: each domain is held in
// reset for HOLD_CYCLES, then released, then (optionally) its ready is awaited
// before the next domain's turn. Loss of PLL lock drops every domain at once;
// a soft reset request restarts sequencing from the lowest requested domain.
// Optional feature: define PRCI_RSTSEQ_TIMEOUT_EN to build the ready-wait
// timeout counter and the sticky o_timeout flags. Without it the sequencer
// waits for ready indefinitely and o_timeout is constant zero.
module prci_rstseq #(
    parameter int unsigned            NUM_DOMAINS   = 4,
    parameter int unsigned            LOCK_FILTER   = 8,
    parameter int unsigned            HOLD_CYCLES   = 16,
    parameter logic [NUM_DOMAINS-1:0] READY_MASK    = '0,
    parameter int unsigned            READY_TIMEOUT = 65535
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_pll_lock,
    input  logic [NUM_DOMAINS-1:0] i_ready,
    input  logic [NUM_DOMAINS-1:0] i_sw_reset,
    output logic [NUM_DOMAINS-1:0] o_nrst,
    output logic [NUM_DOMAINS-1:0] o_timeout,
    output logic                   o_busy,
    output logic [2:0]             o_state
);

    // Externally visible state encoding.
    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_HOLD      = 3'd1;
    localparam logic [2:0] ST_WAIT_RDY  = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;

    localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int unsigned LCK_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int unsigned HLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_FILTER - 1);
    localparam logic [HLD_W-1:0] HOLD_LAST = HLD_W'(HOLD_CYCLES - 1);

    // Elaboration-time parameter range guards.
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16) begin : g_bad_num_domains
        $error("prci_rstseq: NUM_DOMAINS must be in 1..16");
    end
    if (LOCK_FILTER < 1) begin : g_bad_lock_filter
        $error("prci_rstseq: LOCK_FILTER must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $error("prci_rstseq: HOLD_CYCLES must be >= 1");
    end
    if (READY_TIMEOUT < 1) begin : g_bad_ready_timeout
        $error("prci_rstseq: READY_TIMEOUT must be >= 1");
    end

    logic [2:0]             state;
    logic [2:0]             state_d;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_d;
    logic [LCK_W-1:0]       lock_cnt;
    logic [LCK_W-1:0]       lock_cnt_d;
    logic [HLD_W-1:0]       hold_cnt;
    logic [HLD_W-1:0]       hold_cnt_d;
    logic [NUM_DOMAINS-1:0] nrst_d;

    logic                   sw_hit;
    logic [IDX_W-1:0]       sw_m;
    logic [NUM_DOMAINS-1:0] keep_mask;
    logic [NUM_DOMAINS-1:0] rel_bit;
    logic                   lose_lock;
    logic                   sw_take;
    logic                   rdy_ok;
    logic                   tmo_hit;
    logic                   leave_rdy;

`ifdef PRCI_RSTSEQ_TIMEOUT_EN
    localparam int unsigned      TMO_W    = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(READY_TIMEOUT - 1);

    logic [TMO_W-1:0]       tmo_cnt;
    logic [TMO_W-1:0]       tmo_cnt_d;
    logic [NUM_DOMAINS-1:0] timeout_d;

    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // Lowest requested soft-reset domain; the descending scan leaves the lowest set bit last.
    always_comb begin
        sw_hit = 1'b0;
        sw_m   = '0;
        for (int unsigned j = NUM_DOMAINS; j > 0; j--) begin
            if (i_sw_reset[j-1]) begin
                sw_hit = 1'b1;
                sw_m   = IDX_W'(j - 1);
            end
        end
    end

    // Per-domain masks: domains kept out of a soft reset, and the domain whose turn it is.
    always_comb begin
        keep_mask = '0;
        rel_bit   = '0;
        for (int unsigned j = 0; j < NUM_DOMAINS; j++) begin
            keep_mask[j] = (IDX_W'(j) < sw_m);
            rel_bit[j]   = (IDX_W'(j) == idx);
        end
    end

    // Event qualification shared by the state and timeout logic.
    always_comb begin
        lose_lock = (state != ST_WAIT_LOCK) && !i_pll_lock;
        sw_take   = sw_hit && ((state == ST_RUN) ||
                               (((state == ST_HOLD) || (state == ST_WAIT_RDY)) && (sw_m <= idx)));
        rdy_ok    = !READY_MASK[idx] || i_ready[idx];
        leave_rdy = rdy_ok || tmo_hit;
    end

    // Next-state logic. Priority: lock loss, then soft reset, then normal sequencing.
    // Counters default to zero so every exit path clears them without extra code.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        nrst_d     = o_nrst;
        lock_cnt_d = '0;
        hold_cnt_d = '0;

        if (lose_lock) begin
            state_d = ST_WAIT_LOCK;
            idx_d   = '0;
            nrst_d  = '0;
        end else if (sw_take) begin
            state_d = ST_HOLD;
            idx_d   = sw_m;
            nrst_d  = o_nrst & keep_mask;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    if (i_pll_lock) begin
                        if (lock_cnt == LOCK_LAST) begin
                            state_d = ST_HOLD;
                            idx_d   = '0;
                        end else begin
                            lock_cnt_d = lock_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        nrst_d  = o_nrst | rel_bit;
                        state_d = ST_WAIT_RDY;
                    end else begin
                        hold_cnt_d = hold_cnt + 1'b1;
                    end
                end
                ST_WAIT_RDY: begin
                    if (leave_rdy) begin
                        if (idx == IDX_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_HOLD;
                            idx_d   = idx + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    idx_d   = '0;
                    nrst_d  = '0;
                end
            endcase
        end
    end

    // Sequencer state and domain reset registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state    <= ST_WAIT_LOCK;
            idx      <= '0;
            lock_cnt <= '0;
            hold_cnt <= '0;
            o_nrst   <= '0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            lock_cnt <= lock_cnt_d;
            hold_cnt <= hold_cnt_d;
            o_nrst   <= nrst_d;
        end
    end

`ifdef PRCI_RSTSEQ_TIMEOUT_EN
    // Ready-wait timeout: counts only while staying in WAIT_RDY without ready.
    always_comb begin
        tmo_cnt_d = '0;
        timeout_d = o_timeout;
        if ((state == ST_WAIT_RDY) && !lose_lock && !sw_take && !rdy_ok) begin
            if (tmo_hit) begin
                timeout_d = o_timeout | rel_bit;
            end else begin
                tmo_cnt_d = tmo_cnt + 1'b1;
            end
        end
    end

    // Timeout counter and sticky flags; flags clear only on i_nrst.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            tmo_cnt   <= '0;
            o_timeout <= '0;
        end else begin
            tmo_cnt   <= tmo_cnt_d;
            o_timeout <= timeout_d;
        end
    end
`else
    assign o_timeout = '0;
`endif

    assign o_busy  = (state != ST_RUN);
    assign o_state = state;

endmodule

// File: tb/tb_prci_rstseq.sv
// tb_prci_rstseq -- scoreboard bench for prci_rstseq.
// Stimulus drives inputs on the falling edge and pushes the reference model's
// expected outputs for the following rising edge; a monitor pops and compares
// shortly after each rising edge. Directed sections add spec-constant checks.
module tb_prci_rstseq;

    localparam int N  = 3;
    localparam int LF = 2;
    localparam int HC = 4;
    localparam int RT = 10;
    localparam logic [N-1:0] RMASK = 3'b010;

    logic         i_clk = 1'b1;
    logic         i_nrst;
    logic         i_pll_lock;
    logic [N-1:0] i_ready;
    logic [N-1:0] i_sw_reset;
    logic [N-1:0] o_nrst;
    logic [N-1:0] o_timeout;
    logic         o_busy;
    logic [2:0]   o_state;

    prci_rstseq #(
        .NUM_DOMAINS  (N),
        .LOCK_FILTER  (LF),
        .HOLD_CYCLES  (HC),
        .READY_MASK   (RMASK),
        .READY_TIMEOUT(RT)
    ) dut (
        .i_clk     (i_clk),
        .i_nrst    (i_nrst),
        .i_pll_lock(i_pll_lock),
        .i_ready   (i_ready),
        .i_sw_reset(i_sw_reset),
        .o_nrst    (o_nrst),
        .o_timeout (o_timeout),
        .o_busy    (o_busy),
        .o_state   (o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [N-1:0] nrst;
        logic [N-1:0] tmo;
        logic         busy;
        logic [2:0]   state;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Reference model in terms of "domains released", "whose turn", and
    // "cycles since this turn/wait began".
    int           m_lock_run;
    int           m_cur;
    int           m_rel;
    int           m_age;
    bit           m_locked;
    bit           m_done;
    logic [N-1:0] m_tmo;

    function automatic void model_reset();
        m_lock_run = 0;
        m_cur      = 0;
        m_rel      = 0;
        m_age      = 0;
        m_locked   = 0;
        m_done     = 0;
        m_tmo      = '0;
    endfunction

    function automatic void model_step(input bit lock, input logic [N-1:0] rdy, input logic [N-1:0] sw);
        int m;
        bit go;
        m = -1;
        for (int k = N - 1; k >= 0; k--) if (sw[k]) m = k;
        if (!m_locked) begin
            m_lock_run = lock ? m_lock_run + 1 : 0;
            if (m_lock_run == LF) begin
                m_locked   = 1;
                m_lock_run = 0;
                m_cur      = 0;
                m_rel      = 0;
                m_age      = 0;
                m_done     = 0;
            end
        end else if (!lock) begin
            m_locked   = 0;
            m_lock_run = 0;
            m_rel      = 0;
            m_cur      = 0;
            m_age      = 0;
            m_done     = 0;
        end else if (m >= 0 && (m_done || m <= m_cur)) begin
            m_rel  = m;
            m_cur  = m;
            m_age  = 0;
            m_done = 0;
        end else if (!m_done) begin
            m_age++;
            if (m_rel == m_cur) begin
                if (m_age == HC) begin
                    m_rel = m_cur + 1;
                    m_age = 0;
                end
            end else begin
                go = !RMASK[m_cur] || rdy[m_cur];
`ifdef PRCI_RSTSEQ_TIMEOUT_EN
                if (!go && m_age == RT) begin
                    m_tmo[m_cur] = 1'b1;
                    go = 1;
                end
`endif
                if (go) begin
                    if (m_cur == N - 1) m_done = 1;
                    else begin
                        m_cur++;
                        m_age = 0;
                    end
                end
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int k = 0; k < N; k++) e.nrst[k] = (k < m_rel);
        e.tmo = m_tmo;
        if (!m_locked)           e.state = 3'd0;
        else if (m_done)         e.state = 3'd3;
        else if (m_rel == m_cur) e.state = 3'd1;
        else                     e.state = 3'd2;
        e.busy = (e.state != 3'd3);
        return e;
    endfunction

    task automatic cycle(input bit lock, input logic [N-1:0] rdy, input logic [N-1:0] sw, input bit nrst);
        @(negedge i_clk);
        i_pll_lock = lock;
        i_ready    = rdy;
        i_sw_reset = sw;
        i_nrst     = nrst;
        if (!nrst) model_reset();
        else       model_step(lock, rdy, sw);
        sb.push_back(model_out());
    endtask

    // Monitor: compare every registered output against the queued expectation.
    initial begin
        exp_t         e;
        logic [N:0]   inc;
        forever begin
            @(posedge i_clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_nrst",    o_nrst,    e.nrst);
                check("sb_timeout", o_timeout, e.tmo);
                check("sb_busy",    o_busy,    e.busy);
                check("sb_state",   o_state,   e.state);
                inc = {1'b0, o_nrst} + 1'b1;
                check("nrst_ascending", ((inc[N-1:0] & o_nrst) == '0), 1);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        int           rise;
        int           sw_hold;
        bit           lk;
        logic [N-1:0] rd;
        logic [N-1:0] swv;

        i_nrst     = 1'b0;
        i_pll_lock = 1'b0;
        i_ready    = '0;
        i_sw_reset = '0;
        model_reset();

        repeat (3) cycle(0, '0, '0, 0);
        check("rst_nrst",    o_nrst,    0);
        check("rst_timeout", o_timeout, 0);
        check("rst_busy",    o_busy,    1);
        check("rst_state",   o_state,   0);

        // Lock high from reset release: domain 0 releases on the 6th edge.
        rise = 0;
        for (int n = 1; n <= 30 && rise == 0; n++) begin
            cycle(1, 3'b010, '0, 1);
            @(posedge i_clk);
            #1;
            if (o_nrst[0]) rise = n;
        end
        check("lock_to_nrst0_edges", rise, 6);
        repeat (12) cycle(1, 3'b010, '0, 1);
        check("seq_done_nrst",  o_nrst,  3'b111);
        check("seq_done_busy",  o_busy,  0);
        check("seq_done_state", o_state, 3);

        // One-cycle soft reset of domain 1 while running.
        cycle(1, 3'b010, 3'b010, 1);
        cycle(1, 3'b000, '0, 1);
        check("swrst_nrst",  o_nrst,  3'b001);
        check("swrst_state", o_state, 1);

        repeat (30) cycle(1, 3'b000, '0, 1);
`ifdef PRCI_RSTSEQ_TIMEOUT_EN
        check("tmo_flags", o_timeout, 3'b010);
        check("tmo_nrst",  o_nrst,    3'b111);
        check("tmo_busy",  o_busy,    0);
`else
        check("norady_nrst",    o_nrst,    3'b011);
        check("norady_state",   o_state,   2);
        check("norady_busy",    o_busy,    1);
        check("norady_timeout", o_timeout, 0);

        // Ready[1] asserted after edge t: full release exactly at edge t+5.
        repeat (5) cycle(1, 3'b010, '0, 1);
        check("rdy_t4_nrst", o_nrst, 3'b011);
        cycle(1, 3'b010, '0, 1);
        check("rdy_t5_nrst", o_nrst, 3'b111);
`endif
        repeat (2) cycle(1, 3'b010, '0, 1);

        // One-cycle lock loss while running.
        cycle(0, 3'b010, '0, 1);
        cycle(1, 3'b010, '0, 1);
        check("lockloss_nrst",  o_nrst,  3'b000);
        check("lockloss_state", o_state, 0);
        cycle(1, 3'b010, '0, 1);
        check("relock_filter_state", o_state, 0);
        cycle(1, 3'b010, '0, 1);
        check("relock_hold_state", o_state, 1);
        repeat (20) cycle(1, 3'b010, '0, 1);
        check("reseq_nrst",  o_nrst,  3'b111);
        check("reseq_state", o_state, 3);

        // Randomized lock glitches, soft-reset pulses/holds and ready patterns.
        sw_hold = 0;
        swv     = '0;
        for (int c = 0; c < 2000; c++) begin
            lk = ($urandom_range(0, 59) != 0);
            rd = 3'($urandom_range(0, 7));
            if (sw_hold > 0) begin
                sw_hold--;
            end else if ($urandom_range(0, 29) == 0) begin
                swv     = 3'($urandom_range(1, 7));
                sw_hold = $urandom_range(0, 4);
            end else begin
                swv = '0;
            end
            cycle(lk, rd, swv, 1);
        end

        // Asynchronous reset mid-run clears everything without a clock edge.
        cycle(1, 3'b010, '0, 0);
        #1;
        check("async_nrst",    o_nrst,    0);
        check("async_timeout", o_timeout, 0);
        check("async_busy",    o_busy,    1);
        check("async_state",   o_state,   0);
        cycle(1, 3'b010, '0, 0);
        repeat (4) cycle(1, 3'b010, '0, 1);

        @(posedge i_clk);
        #3;
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
